bufgce_div_multi: RTL and testbench

- Multi-channel, runtime-programmable clock divider. Successor to the single-channel fixed-divide buffer divider.
- NUM_CH independent divided outputs come from one source clock. Each channel has:
  - its own divide ratio of up to 2^DIV_W-1;
  - a glitch-free clock enable;
  - a ratio reload that takes effect only at a period boundary.
- A common ALIGN input phase-aligns all channels.
- Used to generate related low-rate clocks/strobes for simulation models of the clock-management fabric.

---
 rtl/bufgce_div_pkg.sv | 23 ++
 rtl/bufgce_div_ch.sv | 151 +++++++++++++++
 rtl/bufgce_div_multi.sv | 57 +++++
 tb/tb_bufgce_div_multi.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bufgce_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package bufgce_div_pkg;

  // Widest divide ratio any channel can be built with.
  localparam int unsigned MaxDivW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStopping
  } ch_state_e;

  // Ratios 0 and 1 cannot form a high and a low phase, so they run as 2.
  function automatic logic [MaxDivW-1:0] clamp_div(input logic [MaxDivW-1:0] n);
    return (n < MaxDivW'(2)) ? MaxDivW'(2) : n;
  endfunction

  // Length of the high phase, ceil(n/2), computed without overflow.
  function automatic logic [MaxDivW-1:0] half_ceil(input logic [MaxDivW-1:0] n);
    return (n >> 1) + MaxDivW'(n[0]);
  endfunction

endpackage

// File: rtl/bufgce_div_ch.sv
// One divider channel: CE synchroniser, period counter, run/stop FSM and ratio reload.
module bufgce_div_ch
  import bufgce_div_pkg::*;
#(
  parameter int unsigned DIV_W          = 4,
  parameter int unsigned DEFAULT_DIV    = 2,
  parameter int unsigned CE_SYNC_STAGES = 2,
  parameter logic        CE_INVERTED    = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             load_i,
  input  logic             align_i,
  output logic             o_o,
  output logic             tick_o,
  output logic [DIV_W-1:0] div_act_o,
  output logic             pend_o
);

  logic ce_raw;
  logic ce_s;

  assign ce_raw = ce_i ^ CE_INVERTED;

  if (CE_SYNC_STAGES == 0) begin : g_ce_direct
    assign ce_s = ce_raw;
  end else begin : g_ce_sync
    logic [CE_SYNC_STAGES-1:0] sync_q;

    // Bring CE into the I domain; clearing with reset makes CE during reset invisible.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= ce_raw;
        for (int i = 1; i < int'(CE_SYNC_STAGES); i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign ce_s = sync_q[CE_SYNC_STAGES-1];
  end

  ch_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pval_q, pval_d;
  logic             pend_q, pend_d;
  logic             o_q, o_d;
  logic             tick_q, tick_d;

  logic [DIV_W-1:0]   cnt_nxt;
  logic [MaxDivW-1:0] half;
  logic               wrap;
  logic               apply;

  assign cnt_nxt = cnt_q + DIV_W'(1);
  assign half    = half_ceil(MaxDivW'(div_q));
  assign wrap    = (cnt_q == div_q - DIV_W'(1));

  // Next-state: align beats wrap beats count; the run/stop decision is taken at period starts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pval_d  = pval_q;
    pend_d  = pend_q;
    o_d     = o_q;
    tick_d  = 1'b0;
    apply   = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        o_d   = 1'b0;
        apply = pend_q;
        if (ce_s) begin
          state_d = StRun;
          o_d     = 1'b1;
          tick_d  = 1'b1;
        end
      end
      StRun, StStopping: begin
        if (align_i) begin
          apply   = pend_q;
          cnt_d   = '0;
          o_d     = 1'b1;
          tick_d  = 1'b1;
          state_d = ce_s ? StRun : StStopping;
        end else if (wrap) begin
          apply = pend_q;
          cnt_d = '0;
          if (ce_s) begin
            state_d = StRun;
            o_d     = 1'b1;
            tick_d  = 1'b1;
          end else begin
            // Low phase already finished, so stopping here cannot truncate anything.
            state_d = StIdle;
            o_d     = 1'b0;
          end
        end else begin
          cnt_d   = cnt_nxt;
          o_d     = (MaxDivW'(cnt_nxt) < half);
          state_d = ce_s ? StRun : StStopping;
        end
      end
      default: state_d = StIdle;
    endcase

    if (apply) begin
      div_d  = pval_q;
      pend_d = 1'b0;
    end
    // A load on an apply edge is kept for the next boundary.
    if (load_i) begin
      pval_d = DIV_W'(clamp_div(MaxDivW'(div_i)));
      pend_d = 1'b1;
    end
  end

  // Channel state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= DIV_W'(DEFAULT_DIV);
      pval_q  <= DIV_W'(DEFAULT_DIV);
      pend_q  <= 1'b0;
      o_q     <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      o_q     <= o_d;
      tick_q  <= tick_d;
    end
  end

  assign o_o       = o_q;
  assign tick_o    = tick_q;
  assign div_act_o = div_q;
  assign pend_o    = pend_q;

endmodule

// File: rtl/bufgce_div_multi.sv
// Multi-channel programmable clock divider with shared reset synchroniser and ALIGN.
module bufgce_div_multi
  import bufgce_div_pkg::*;
#(
  parameter int unsigned       NUM_CH         = 4,
  parameter int unsigned       DIV_W          = 4,
  parameter int unsigned       DEFAULT_DIV    = 2,
  parameter int unsigned       CE_SYNC_STAGES = 2,
  parameter logic [NUM_CH-1:0] IS_CE_INVERTED = '0
) (
  input  logic                    I,
  input  logic                    CLR_N,
  input  logic [NUM_CH-1:0]       CE,
  input  logic [NUM_CH*DIV_W-1:0] DIV_IN,
  input  logic [NUM_CH-1:0]       LOAD,
  input  logic                    ALIGN,
  output logic [NUM_CH-1:0]       O,
  output logic [NUM_CH-1:0]       O_TICK,
  output logic [NUM_CH*DIV_W-1:0] DIV_ACT,
  output logic [NUM_CH-1:0]       PEND
);

  logic rst_meta_q;
  logic rst_sync_q;

  // Assert reset at once, release it two I edges later.
  always_ff @(posedge I or negedge CLR_N) begin
    if (!CLR_N) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_ch
    bufgce_div_ch #(
      .DIV_W          (DIV_W),
      .DEFAULT_DIV    (DEFAULT_DIV),
      .CE_SYNC_STAGES (CE_SYNC_STAGES),
      .CE_INVERTED    (IS_CE_INVERTED[k])
    ) u_ch (
      .clk_i     (I),
      .rst_ni    (rst_sync_q),
      .ce_i      (CE[k]),
      .div_i     (DIV_IN[k*DIV_W +: DIV_W]),
      .load_i    (LOAD[k]),
      .align_i   (ALIGN),
      .o_o       (O[k]),
      .tick_o    (O_TICK[k]),
      .div_act_o (DIV_ACT[k*DIV_W +: DIV_W]),
      .pend_o    (PEND[k])
    );
  end

endmodule

// File: tb/tb_bufgce_div_multi.sv
// Randomised and directed bench for bufgce_div_multi against a period-level reference model.
module tb_bufgce_div_multi;

  localparam int NUM_CH      = 4;
  localparam int DIV_W       = 4;
  localparam int DEFAULT_DIV = 2;
  localparam int STAGES      = 2;
  localparam int DW          = NUM_CH * DIV_W;

  logic              I = 1'b0;
  logic              CLR_N = 1'b0;
  logic [NUM_CH-1:0] CE = '0;
  logic [DW-1:0]     DIV_IN = '0;
  logic [NUM_CH-1:0] LOAD = '0;
  logic              ALIGN = 1'b0;
  logic [NUM_CH-1:0] O;
  logic [NUM_CH-1:0] O_TICK;
  logic [DW-1:0]     DIV_ACT;
  logic [NUM_CH-1:0] PEND;

  always #5 I = ~I;

  bufgce_div_multi #(
    .NUM_CH         (NUM_CH),
    .DIV_W          (DIV_W),
    .DEFAULT_DIV    (DEFAULT_DIV),
    .CE_SYNC_STAGES (STAGES),
    .IS_CE_INVERTED ('0)
  ) dut (
    .I       (I),
    .CLR_N   (CLR_N),
    .CE      (CE),
    .DIV_IN  (DIV_IN),
    .LOAD    (LOAD),
    .ALIGN   (ALIGN),
    .O       (O),
    .O_TICK  (O_TICK),
    .DIV_ACT (DIV_ACT),
    .PEND    (PEND)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: each channel is either running at some position of its period or not.
  int m_n    [NUM_CH];
  int m_pv   [NUM_CH];
  int m_pos  [NUM_CH];
  bit m_run  [NUM_CH];
  bit m_pend [NUM_CH];
  bit m_tick [NUM_CH];
  bit m_hist [NUM_CH][STAGES];
  int m_rst_cnt;

  logic [DW-1:0] def_pat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_n[k]    = DEFAULT_DIV;
      m_pv[k]   = DEFAULT_DIV;
      m_pos[k]  = 0;
      m_run[k]  = 1'b0;
      m_pend[k] = 1'b0;
      m_tick[k] = 1'b0;
      for (int s = 0; s < STAGES; s++) m_hist[k][s] = 1'b0;
    end
    m_rst_cnt = 0;
  endtask

  // Advance the model by one I edge using the inputs the DUT saw at that edge.
  task automatic model_edge();
    bit ce_s;
    int d;
    if (!CLR_N) begin
      model_reset();
      return;
    end
    if (m_rst_cnt < 2) begin
      m_rst_cnt++;
      return;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      ce_s = m_hist[k][STAGES-1];
      for (int s = STAGES - 1; s > 0; s--) m_hist[k][s] = m_hist[k][s-1];
      m_hist[k][0] = CE[k];
      m_tick[k] = 1'b0;
      if (!m_run[k]) begin
        if (m_pend[k]) begin
          m_n[k]    = m_pv[k];
          m_pend[k] = 1'b0;
        end
        if (ce_s) begin
          m_run[k]  = 1'b1;
          m_pos[k]  = 0;
          m_tick[k] = 1'b1;
        end
      end else if (ALIGN || m_pos[k] == m_n[k] - 1) begin
        if (m_pend[k]) begin
          m_n[k]    = m_pv[k];
          m_pend[k] = 1'b0;
        end
        m_pos[k] = 0;
        if (ALIGN || ce_s) m_tick[k] = 1'b1;
        else m_run[k] = 1'b0;
      end else begin
        m_pos[k]++;
      end
      if (LOAD[k]) begin
        d         = int'(DIV_IN[k*DIV_W +: DIV_W]);
        m_pv[k]   = (d < 2) ? 2 : d;
        m_pend[k] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0] eo, et, ep;
    logic [DW-1:0]     ed;
    for (int k = 0; k < NUM_CH; k++) begin
      eo[k] = m_run[k] && (m_pos[k] < (m_n[k] + 1) / 2);
      et[k] = m_tick[k];
      ep[k] = m_pend[k];
      ed[k*DIV_W +: DIV_W] = DIV_W'(m_n[k]);
    end
    check("O", 64'(O), 64'(eo));
    check("O_TICK", 64'(O_TICK), 64'(et));
    check("DIV_ACT", 64'(DIV_ACT), 64'(ed));
    check("PEND", 64'(PEND), 64'(ep));
  endtask

  task automatic step();
    @(posedge I);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_ch(input int ch, input int val);
    DIV_IN[ch*DIV_W +: DIV_W] = DIV_W'(val);
    LOAD = '0;
    LOAD[ch] = 1'b1;
    step();
    LOAD = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    for (int k = 0; k < NUM_CH; k++) def_pat[k*DIV_W +: DIV_W] = DIV_W'(DEFAULT_DIV);
    model_reset();

    // Reset held with CE already high.
    CE = '1;
    steps(3);
    check("rst_O", 64'(O), 64'(0));
    check("rst_DIV_ACT", 64'(DIV_ACT), 64'(def_pat));
    check("rst_PEND", 64'(PEND), 64'(0));
    CLR_N = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i < 5) check("pre_rise", 64'(O), 64'(0));
      else check("first_rise", 64'(O), 64'(4'hF));
    end
    steps(6);

    // Odd ratio on ch1.
    load_ch(1, 5);
    check("pend1_set", 64'(PEND[1]), 64'(1));
    steps(14);

    // Ratio 6 on ch2, then stop, restart and a one-cycle CE dip.
    load_ch(2, 6);
    steps(12);
    CE[2] = 1'b0;
    steps(14);
    CE[2] = 1'b1;
    steps(14);
    CE[2] = 1'b0;
    step();
    CE[2] = 1'b1;
    steps(20);

    // ALIGN with only ch0 (ratio 3) and ch3 (ratio 7) running, ch3 reload pending.
    load_ch(0, 3);
    load_ch(3, 7);
    CE = 4'b1001;
    steps(20);
    load_ch(3, 4);
    ALIGN = 1'b1;
    step();
    ALIGN = 1'b0;
    check("align_tick", 64'(O_TICK), 64'(4'b1001));
    check("align_O", 64'(O & 4'b1001), 64'(4'b1001));
    check("align_div3", 64'(DIV_ACT[3*DIV_W +: DIV_W]), 64'(4));
    steps(10);

    // Clamp, then asynchronous reset mid-period.
    load_ch(0, 0);
    steps(8);
    check("clamp", 64'(DIV_ACT[DIV_W-1:0]), 64'(2));
    CE = '1;
    steps(7);
    #2;
    CLR_N = 1'b0;
    model_reset();
    #1;
    check("async_O", 64'(O), 64'(0));
    check("async_DIV_ACT", 64'(DIV_ACT), 64'(def_pat));
    check("async_PEND", 64'(PEND), 64'(0));
    steps(2);
    CLR_N = 1'b1;
    steps(8);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0) begin
        idx = int'($urandom_range(NUM_CH - 1));
        CE[idx] = ~CE[idx];
      end
      for (int k = 0; k < NUM_CH; k++) LOAD[k] = ($urandom_range(7) == 0);
      DIV_IN = DW'($urandom);
      ALIGN  = ($urandom_range(19) == 0);
      if (i == 400) CLR_N = 1'b0;
      if (i == 403) CLR_N = 1'b1;
      step();
    end
    LOAD  = '0;
    ALIGN = 1'b0;
    steps(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
